// File: rtl/apb_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile_if
//   APB bus bundle between a requester (the bridge) and the register-file
//   completer.
//   Pselx   [2:0]  slave selects           (master -> slave)
//   Penable        access phase            (master -> slave)
//   Pwrite         1=write, 0=read         (master -> slave)
//   Paddr   [31:0] byte address            (master -> slave)
//   Pwdata  [31:0] write data              (master -> slave)
//   Prdata  [31:0] read data               (slave -> master)
//   Pready         transfer completes      (slave -> master)
//   Pslverr        error, valid w/ Pready  (slave -> master)
// -----------------------------------------------------------------------------
interface apb_slave_regfile_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//   APB completer backed by a DEPTH x 32-bit register file, with a fixed
//   number of wait states per transfer and error responses for misaligned
//   or out-of-window addresses.
//   Hclk    rising-edge clock
//   Hreset  synchronous reset, active-high (clears state and all words)
//   bus     apb_slave_regfile_if.slave; only Pselx[SEL_IDX] selects this block
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          SEL_IDX     = 0
) (
  input  logic                Hclk,
  input  logic                Hreset,
  apb_slave_regfile_if.slave  bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]    state_q,    state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          addr_err_q, addr_err_d;
  logic [AW-1:0] idx_l_q,    idx_l_d;
  logic          wr_l_q,     wr_l_d;
  logic [31:0]   wdata_l_q,  wdata_l_d;
  logic [31:0]   rdata_l_q,  rdata_l_d;
  logic [31:0]   mem_q [DEPTH];

  logic          sel;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          err;
  logic          mem_we;
  logic          ready;

  // Only one select bit belongs to this block; the rest are deliberately ignored.
  logic unused_sel;
  assign unused_sel = ^bus.Pselx;

  // Address decode. Addresses below the base wrap to a huge offset, so the
  // explicit below-base term only documents the intent.
  assign sel = bus.Pselx[SEL_IDX];
  assign off = bus.Paddr - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign err = (bus.Paddr[1:0] != 2'b00) | (bus.Paddr < BASE_ADDR) | (off >= SPAN);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_err_d = addr_err_q;
    idx_l_d    = idx_l_q;
    wr_l_d     = wr_l_q;
    wdata_l_d  = wdata_l_q;
    rdata_l_d  = rdata_l_q;
    mem_we     = 1'b0;

    if (sel && !bus.Penable) begin
      // Setup phase: accepted from IDLE, and from ACCESS it drops the
      // in-flight transfer and starts over with the new request.
      addr_err_d = err;
      idx_l_d    = idx;
      wr_l_d     = bus.Pwrite;
      wdata_l_d  = bus.Pwdata;
      rdata_l_d  = err ? 32'h0 : mem_q[idx];
      wait_cnt_d = 4'(WAIT_STATES);
      state_d    = ST_ACCESS;
    end else if (state_q == ST_ACCESS) begin
      if (!sel) begin
        state_d = ST_IDLE;                     // abort: nothing committed
      end else if (wait_cnt_q != 4'd0) begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end else begin
        mem_we  = wr_l_q & ~addr_err_q;
        state_d = ST_IDLE;
      end
    end
    // IDLE with sel & Penable but no setup falls through: ignored.
  end

  assign ready       = (state_q == ST_ACCESS) && (wait_cnt_q == 4'd0);
  assign bus.Pready  = ready;
  assign bus.Pslverr = ready & addr_err_q;
  assign bus.Prdata  = (ready && !wr_l_q && !addr_err_q) ? rdata_l_q : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      addr_err_q <= 1'b0;
      idx_l_q    <= '0;
      wr_l_q     <= 1'b0;
      wdata_l_q  <= 32'h0;
      rdata_l_q  <= 32'h0;
      // NOTE: the register file must read as zero after reset, so the words
      // are individual flops with reset rather than an unreset RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_err_q <= addr_err_d;
      idx_l_q    <= idx_l_d;
      wr_l_q     <= wr_l_d;
      wdata_l_q  <= wdata_l_d;
      rdata_l_q  <= rdata_l_d;
      if (mem_we) mem_q[idx_l_q] <= wdata_l_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//   Drives one APB stimulus stream into two register files that differ only in
//   wait states (0 and 2). Each keeps its own expected memory image, because an
//   access phase that is cut short commits on the fast one but not the slow one.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          SEL   = 1;

  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus1 ();

  assign bus0.Pselx   = pselx;
  assign bus0.Penable = penable;
  assign bus0.Pwrite  = pwrite;
  assign bus0.Paddr   = paddr;
  assign bus0.Pwdata  = pwdata;
  assign bus1.Pselx   = pselx;
  assign bus1.Penable = penable;
  assign bus1.Pwrite  = pwrite;
  assign bus1.Paddr   = paddr;
  assign bus1.Pwdata  = pwdata;

  apb_slave_regfile #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .SEL_IDX(SEL))
    u_ws0 (.Hclk(Hclk), .Hreset(Hreset), .bus(bus0.slave));

  apb_slave_regfile #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2), .SEL_IDX(SEL))
    u_ws2 (.Hclk(Hclk), .Hreset(Hreset), .bus(bus1.slave));

  logic [31:0] obs_rdata [2];
  logic        obs_ready [2];
  logic        obs_err   [2];
  assign obs_rdata[0] = bus0.Prdata;
  assign obs_ready[0] = bus0.Pready;
  assign obs_err[0]   = bus0.Pslverr;
  assign obs_rdata[1] = bus1.Prdata;
  assign obs_ready[1] = bus1.Pready;
  assign obs_err[1]   = bus1.Pslverr;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [2][DEPTH];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) model_mem[d][i] = 32'h0;
  endfunction

  // One APB transfer: setup cycle, then n_acc access cycles. Outputs of both
  // slaves are checked in every access cycle; bus fields are scrambled during
  // the access phase since the slaves must use what they latched at setup.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input int n_acc, input int sel_bit, input string tag);
    bit          err, hit, exp_ready, exp_err;
    int          idx;
    logic [31:0] rd_exp [2];
    logic [31:0] exp_rd;
    err = (addr[1:0] != 2'b00) || (addr < BASE) || (addr >= BASE + 32'(DEPTH * 4));
    idx = err ? 0 : int'((addr - BASE) >> 2);
    hit = (sel_bit == SEL);
    for (int d = 0; d < 2; d++) rd_exp[d] = (!wr && !err) ? model_mem[d][idx] : 32'h0;

    pselx   = 3'(1 << sel_bit);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(posedge Hclk); #1;
    penable = 1'b1;
    for (int j = 1; j <= n_acc; j++) begin
      pwrite = 1'($urandom);
      paddr  = $urandom;
      pwdata = $urandom;
      @(negedge Hclk);
      for (int d = 0; d < 2; d++) begin
        exp_ready = hit && (j == ws_of(d) + 1);
        exp_err   = exp_ready && err;
        exp_rd    = exp_ready ? rd_exp[d] : 32'h0;
        vectors++;
        if ({obs_ready[d], obs_err[d], obs_rdata[d]} !== {exp_ready, exp_err, exp_rd}) begin
          miscompares++;
          $display("FAIL %s ws%0d acc%0d: got rdy=%0b err=%0b rdata=%h, want rdy=%0b err=%0b rdata=%h",
                   tag, ws_of(d), j, obs_ready[d], obs_err[d], obs_rdata[d],
                   exp_ready, exp_err, exp_rd);
        end
      end
      @(posedge Hclk); #1;
    end

    for (int d = 0; d < 2; d++)
      if (hit && wr && !err && n_acc >= ws_of(d) + 1) model_mem[d][idx] = data;
  endtask

  task automatic idle_cycles(input int n);
    pselx   = 3'b000;
    penable = 1'b0;
    repeat (n) begin
      @(posedge Hclk); #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({obs_ready[d], obs_err[d], obs_rdata[d]} !== {1'b0, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL %s ws%0d: got rdy=%0b err=%0b rdata=%h, want all zero",
                 tag, ws_of(d), obs_ready[d], obs_err[d], obs_rdata[d]);
      end
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++)
      do_xfer(1'b0, BASE + 32'(i * 4), 32'h0, 3, SEL, tag);
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    idle_cycles(2);
    Hreset = 1'b0;
    model_clear();
    @(negedge Hclk);
    check_quiet("reset_outputs");
    @(posedge Hclk); #1;
    read_all("reset_readback");
  endtask

  task automatic test_write_read();
    do_xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 3, SEL, "wr_8");
    do_xfer(1'b0, BASE + 32'h8, 32'h0, 3, SEL, "rd_8");
  endtask

  task automatic test_wait_states();
    do_xfer(1'b1, BASE + 32'h4, $urandom, 3, SEL, "wr_4");
    idle_cycles(1);
    do_xfer(1'b0, BASE + 32'h4, 32'h0, 3, SEL, "rd_4_waits");
  endtask

  task automatic test_errors();
    do_xfer(1'b1, BASE + 32'h40, 32'hBAD0_0001, 3, SEL, "err_wr_past_end");
    do_xfer(1'b1, BASE + 32'h2,  32'hBAD0_0002, 3, SEL, "err_wr_misaligned");
    do_xfer(1'b1, BASE - 32'h4,  32'hBAD0_0003, 3, SEL, "err_wr_below_base");
    do_xfer(1'b0, BASE + 32'h44, 32'h0,         3, SEL, "err_rd_past_end");
    do_xfer(1'b0, BASE + 32'h3D, 32'h0,         3, SEL, "err_rd_misaligned");
    read_all("err_readback");
  endtask

  task automatic test_no_setup();
    pselx   = 3'(1 << SEL);
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = BASE + 32'h18;
    pwdata  = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge Hclk);
      check_quiet("enable_without_setup");
      @(posedge Hclk); #1;
    end
    idle_cycles(1);
    do_xfer(1'b0, BASE + 32'h18, 32'h0, 3, SEL, "no_setup_readback");
  endtask

  task automatic test_abort_and_reset();
    // Cut short after 1 and 2 access cycles: commits only where no wait remains.
    do_xfer(1'b1, BASE + 32'hC,  32'h0000_1234, 1, SEL, "abort_after_1");
    idle_cycles(1);
    do_xfer(1'b1, BASE + 32'h14, 32'h0000_5678, 2, SEL, "abort_after_2");
    idle_cycles(1);
    do_xfer(1'b0, BASE + 32'hC,  32'h0, 3, SEL, "abort_rd_c");
    do_xfer(1'b0, BASE + 32'h14, 32'h0, 3, SEL, "abort_rd_14");
    // Reset lands during the first access cycle: nothing may commit.
    pselx   = 3'(1 << SEL);
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = BASE + 32'h10;
    pwdata  = 32'hCAFE_F00D;
    @(posedge Hclk); #1;
    penable = 1'b1;
    Hreset  = 1'b1;
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    Hreset  = 1'b0;
    pselx   = 3'b000;
    penable = 1'b0;
    model_clear();
    @(negedge Hclk);
    check_quiet("reset_mid_access");
    @(posedge Hclk); #1;
    read_all("post_reset_readback");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++)
      do_xfer(1'b1, BASE + 32'(i * 4), $urandom, 3, SEL, "b2b_wr");
    for (int i = 0; i < DEPTH; i++)
      do_xfer(1'b0, BASE + 32'(i * 4), 32'h0, 3, (i % 2 == 0) ? 0 : 2, "b2b_wrong_sel");
    read_all("b2b_rd");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          sel_bit;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       addr = BASE + 32'($urandom_range(DEPTH, 4 * DEPTH) * 4);
        1:       addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
        default: addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      sel_bit = ($urandom_range(0, 5) == 0) ? 2 : SEL;
      do_xfer(1'($urandom), addr, $urandom, $urandom_range(1, 4), sel_bit, "rand");
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);
    read_all("rand_readback");
  endtask

  initial begin
    Hreset  = 1'b1;
    pselx   = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_errors();
    test_no_setup();
    test_abort_and_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
